// File: rtl/uart_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : uart_frame_pkg                                                  |
// | Purpose   : Shared constants and state encodings for the 22-bit UART link   |
// |             receiver (frame FSM, byte FSM, header prefix).                  |
// | Revision  : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package uart_frame_pkg;

    localparam logic [1:0] HDR_PREFIX      = 2'b10;
    localparam int         BYTES_PER_FRAME = 3;
    localparam int         DATA_W          = 22;

    localparam logic [1:0] FRM_HDR = 2'd0;
    localparam logic [1:0] FRM_B1  = 2'd1;
    localparam logic [1:0] FRM_B2  = 2'd2;

    localparam logic [2:0] BYT_IDLE   = 3'd0;
    localparam logic [2:0] BYT_START  = 3'd1;
    localparam logic [2:0] BYT_DATA   = 3'd2;
    localparam logic [2:0] BYT_STOP   = 3'd3;
    localparam logic [2:0] BYT_PARITY = 3'd4;

    function automatic logic hdr_ok(input logic [7:0] b);
        return b[7:6] == HDR_PREFIX;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : uart_rx_byte                                                    |
// | Purpose   : Two-flop synchronizer plus 8N1 byte deserializer (LSB first).   |
// |             Optional even parity bit when UART_FRAME_RX_PARITY_EN is set.   |
// | Revision  : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_rx_byte
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_done,
    output logic       o_byte_err,
    output logic       o_idle,
    output logic       o_start
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] C_HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] C_FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q, sync_d;
    logic             rx_prev_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             rx_s;
`ifdef UART_FRAME_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
`endif

    assign rx_s = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], i_rx};
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        o_byte_done = 1'b0;
        o_byte_err  = 1'b0;
        o_start     = 1'b0;
`ifdef UART_FRAME_RX_PARITY_EN
        par_bad_d   = par_bad_q;
`endif
        case (state_q)
            // Edge (not level) detection keeps a line stuck low after a bad
            // stop bit from rearming until it has returned high.
            BYT_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = BYT_START;
                    cnt_d   = '0;
                    o_start = 1'b1;
                end
            end
            BYT_START: begin
                if (cnt_q == C_HALF_M1) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = rx_s ? BYT_IDLE : BYT_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            BYT_DATA: begin
                if (cnt_q == C_FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_FRAME_RX_PARITY_EN
                        state_d = BYT_PARITY;
`else
                        state_d = BYT_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_FRAME_RX_PARITY_EN
            BYT_PARITY: begin
                if (cnt_q == C_FULL_M1) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s ^ (^shift_q);
                    state_d   = BYT_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            BYT_STOP: begin
                if (cnt_q == C_FULL_M1) begin
                    cnt_d   = '0;
                    state_d = BYT_IDLE;
`ifdef UART_FRAME_RX_PARITY_EN
                    o_byte_done = rx_s && !par_bad_q;
                    o_byte_err  = !rx_s || par_bad_q;
`else
                    o_byte_done = rx_s;
                    o_byte_err  = !rx_s;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = BYT_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= BYT_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
`ifdef UART_FRAME_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            sync_q    <= sync_d;
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
`ifdef UART_FRAME_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign o_byte = shift_q;
    assign o_idle = (state_q == BYT_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : uart_frame_rx                                                   |
// | Purpose   : Reassembles 3-byte UART frames into 22-bit words with a valid   |
// |             strobe, inter-byte timeout and error pulse.                     |
// |             Optional macro: UART_FRAME_RX_PARITY_EN (even parity per byte). |
// | Revision  : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic              sys_clock,
    input  logic              reset,
    input  logic              UART_RX,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_frame_err,
    output logic              o_busy
);

    localparam int TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W      = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    logic [7:0]        rx_byte;
    logic              byte_done, byte_err, byte_idle, byte_start;

    logic [1:0]        fstate_q, fstate_d;
    logic [5:0]        hdr_q, hdr_d;
    logic [7:0]        b1_q, b1_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              timeout;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk         (sys_clock),
        .rst         (reset),
        .i_rx        (UART_RX),
        .o_byte      (rx_byte),
        .o_byte_done (byte_done),
        .o_byte_err  (byte_err),
        .o_idle      (byte_idle),
        .o_start     (byte_start)
    );

    // A start bit arriving on the expiry cycle keeps the frame alive.
    assign timeout = (fstate_q != FRM_HDR) && byte_idle && !byte_start &&
                     (tmo_q == C_TMO_LAST);

    always_comb begin
        fstate_d = fstate_q;
        hdr_d    = hdr_q;
        b1_d     = b1_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        tmo_d    = tmo_q;

        if (fstate_q == FRM_HDR || byte_start) begin
            tmo_d = '0;
        end else if (byte_idle) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        if (byte_err || timeout) begin
            fstate_d = FRM_HDR;
            err_d    = 1'b1;
        end else if (byte_done) begin
            case (fstate_q)
                FRM_HDR: begin
                    if (hdr_ok(rx_byte)) begin
                        hdr_d    = rx_byte[5:0];
                        fstate_d = FRM_B1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                FRM_B1: begin
                    b1_d     = rx_byte;
                    fstate_d = FRM_B2;
                end
                FRM_B2: begin
                    data_d   = {hdr_q, b1_q, rx_byte};
                    valid_d  = 1'b1;
                    fstate_d = FRM_HDR;
                end
                default: fstate_d = FRM_HDR;
            endcase
        end
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            fstate_q <= FRM_HDR;
            hdr_q    <= '0;
            b1_q     <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            fstate_q <= fstate_d;
            hdr_q    <= hdr_d;
            b1_q     <= b1_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = err_q;
    assign o_busy      = (fstate_q != FRM_HDR);

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_uart_frame_rx                                                |
// | Purpose   : Directed + randomized bench for uart_frame_rx with a byte-list  |
// |             frame model (header prefix, 3-byte assembly, error rules).      |
// | Revision  : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_uart_frame_rx;

    localparam int N    = 16;
    localparam int HALF = N / 2;
    localparam int TOB  = 32;
    localparam int TMO  = TOB * N;
`ifdef UART_FRAME_RX_PARITY_EN
    localparam int BITS_TO_STOP = 10;
`else
    localparam int BITS_TO_STOP = 9;
`endif
    // Start edge -> 2 synchronizer cycles -> half bit -> whole bits to stop
    // centre -> one output register.
    localparam int VALID_LAT = 2 + HALF + BITS_TO_STOP * N + 1;

    logic        sys_clock = 1'b0;
    logic        reset     = 1'b1;
    logic        UART_RX   = 1'b1;
    logic [21:0] o_data;
    logic        o_valid;
    logic        o_frame_err;
    logic        o_busy;

    uart_frame_rx #(
        .CLKS_PER_BIT (N),
        .TIMEOUT_BITS (TOB)
    ) dut (
        .sys_clock   (sys_clock),
        .reset       (reset),
        .UART_RX     (UART_RX),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 sys_clock = ~sys_clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge sys_clock) cyc <= cyc + 1;

    // Observed events
    logic [21:0] got_q[$];
    int          ecnt = 0;
    int          vcnt = 0;
    int          last_valid_cyc = -1;
    int          last_err_cyc   = -1;
    always @(negedge sys_clock) begin
        if (o_valid) begin
            got_q.push_back(o_data);
            vcnt++;
            last_valid_cyc = cyc;
        end
        if (o_frame_err) begin
            ecnt++;
            last_err_cyc = cyc;
        end
    end

    // Reference model: bytes of the current partial frame
    logic [7:0]  pend[$];
    logic [21:0] exp_q[$];
    int          exp_err = 0;

    function automatic void model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            exp_err++;
            pend.delete();
        end else if (pend.size() == 0 && b[7:6] != 2'b10) begin
            exp_err++;
        end else begin
            pend.push_back(b);
            if (pend.size() == 3) begin
                exp_q.push_back({pend[0][5:0], pend[1], pend[2]});
                pend.delete();
            end
        end
    endfunction

    function automatic void model_abort(input bit counts_err);
        if (counts_err && pend.size() != 0) exp_err++;
        pend.delete();
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        UART_RX = v;
        repeat (N) @(negedge sys_clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good_stop, output int start_cyc);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_FRAME_RX_PARITY_EN
        drive_bit(^b);
`endif
        drive_bit(good_stop);
        UART_RX = 1'b1;
        if (!good_stop) repeat (N) @(negedge sys_clock);
        model_byte(b, good_stop);
    endtask

    task automatic send_word(input logic [21:0] w, input int gap_bits);
        int sc;
        send_byte({2'b10, w[21:16]}, 1'b1, sc);
        repeat (gap_bits * N) @(negedge sys_clock);
        send_byte(w[15:8], 1'b1, sc);
        repeat (gap_bits * N) @(negedge sys_clock);
        send_byte(w[7:0], 1'b1, sc);
    endtask

    task automatic idle_bits(input int n);
        repeat (n * N) @(negedge sys_clock);
    endtask

    task automatic check_words(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_word"}, {10'd0, got_q[i]}, {10'd0, exp_q[i]});
        check({tag, "_errs"}, ecnt, exp_err);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int sc, e0, v0, ec0;
        logic [21:0] w;

        // Reset state
        #1;
        check("rst_data", {10'd0, o_data}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_err", {31'd0, o_frame_err}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        repeat (4) @(negedge sys_clock);
        reset = 1'b0;
        idle_bits(2);

        // Single word with latency check
        send_byte(8'h8F, 1'b1, sc);
        check("w1_busy", {31'd0, o_busy}, 32'd1);
        send_byte(8'h0F, 1'b1, sc);
        send_byte(8'h0F, 1'b1, sc);
        check("w1_latency", last_valid_cyc, sc + VALID_LAT);
        check("w1_data", {10'd0, o_data}, 32'h000F0F0F);
        idle_bits(2);
        check_words("w1");

        // Back-to-back words, no idle between bytes
        send_word(22'h3FFFFF, 0);
        send_word(22'h000001, 0);
        idle_bits(2);
        check_words("b2b");

        // Bad header then valid frame
        e0 = ecnt;
        send_byte(8'h4F, 1'b1, sc);
        idle_bits(1);
        check("badhdr_err", ecnt, e0 + 1);
        check("badhdr_busy", {31'd0, o_busy}, 32'd0);
        send_word(22'h123456, 0);
        idle_bits(2);
        check_words("badhdr");

        // Stop bit low on second byte
        v0 = vcnt;
        send_byte(8'hA5, 1'b1, sc);
        send_byte(8'h3C, 1'b0, sc);
        check("stop_busy", {31'd0, o_busy}, 32'd0);
        check("stop_novalid", vcnt, v0);
        check("stop_data_held", {10'd0, o_data}, 32'h00123456);
        send_word(22'h2ABCDE, 1);
        idle_bits(2);
        check_words("stop");

        // Short start glitch is ignored
        e0 = ecnt; v0 = vcnt;
        UART_RX = 1'b0;
        repeat (3) @(negedge sys_clock);
        UART_RX = 1'b1;
        idle_bits(2);
        check("glitch_err", ecnt, e0);
        check("glitch_busy", {31'd0, o_busy}, 32'd0);
        send_word(22'h0055AA, 0);
        idle_bits(2);
        check_words("glitch");

        // Header only, then timeout
        e0 = ecnt;
        send_byte(8'h9E, 1'b1, sc);
        check("tmo_busy_before", {31'd0, o_busy}, 32'd1);
        for (int i = 0; i < 40 * N && ecnt == e0; i++) @(negedge sys_clock);
        model_abort(1'b1);
        check("tmo_fired", ecnt, e0 + 1);
        check("tmo_not_early", {31'd0, last_err_cyc >= sc + 9 * N + TMO}, 32'd1);
        check("tmo_not_late", {31'd0, last_err_cyc <= sc + 10 * N + TMO}, 32'd1);
        check("tmo_busy_after", {31'd0, o_busy}, 32'd0);
        idle_bits(1);
        send_word(22'h1F00F1, 2);
        idle_bits(2);
        check_words("tmo");

        // Reset during data bits of byte 2
        v0 = vcnt;
        send_byte(8'h81, 1'b1, sc);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_data", {10'd0, o_data}, 32'd0);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        check("mid_rst_err", {31'd0, o_frame_err}, 32'd0);
        UART_RX = 1'b1;
        model_abort(1'b0);
        repeat (3) @(negedge sys_clock);
        reset = 1'b0;
        idle_bits(12);
        check("mid_rst_novalid", vcnt, v0);
        send_word(22'h2468AC, 0);
        idle_bits(2);
        check_words("midrst");

        // Randomized words with short random gaps
        ec0 = exp_err;
        for (int k = 0; k < 8; k++) begin
            w = 22'($urandom);
            send_word(w, int'($urandom_range(0, 3)));
            idle_bits(int'($urandom_range(0, 3)));
        end
        idle_bits(2);
        check("rand_no_errs", exp_err, ec0);
        check_words("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
